// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, funct and issue-bundle definitions for the ALU issue stage
package riscv_pkg;

    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 3;
    localparam int ALU_EXT_W  = 7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Non-operand half of an issue bundle; operands are carried alongside since their width is XLEN.
    typedef struct packed {
        logic                  illegal;
        logic                  rd_we;
        logic [REG_ADDR_W-1:0] rd;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [ALU_EXT_W-1:0]  alu_ext;
    } alu_ctrl_t;

    localparam int CTRL_W = $bits(alu_ctrl_t);

    // Total stored width of one buffered issue bundle: {ctrl, op2, op1}.
    function automatic int bundle_w(input int xlen);
        return 2 * xlen + CTRL_W;
    endfunction

endpackage

// File: rtl/riscv_alu_operand_dec.sv
// rtl/riscv_alu_operand_dec.sv - combinational decode of instruction and register data into an ALU bundle
module riscv_alu_operand_dec
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [XLEN-1:0]    i_rs2_data,
    output logic [XLEN-1:0]    o_op1,
    output logic [XLEN-1:0]    o_op2,
    output alu_ctrl_t          o_ctrl
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [6:0]            w_opc;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_is_shift;
    logic signed [11:0]    w_imm12;
    logic signed [31:0]    w_immu32;
    logic [XLEN-1:0]       w_imm_i;
    logic [XLEN-1:0]       w_imm_u;
    logic [XLEN-1:0]       w_shamt_imm;
    logic [XLEN-1:0]       w_shamt_rs2;
    logic [11:0]           w_imm_chk;
    logic                  w_shift_bad;
    logic                  w_illegal;
    logic [ALU_OP_W-1:0]   w_alu_op;
    logic [ALU_EXT_W-1:0]  w_alu_ext;

    assign w_opc      = i_instr[6:0];
    assign w_f3       = i_instr[14:12];
    assign w_f7       = i_instr[31:25];
    assign w_rd       = i_instr[11:7];
    assign w_is_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SR);

    // Signed casts sign-extend the I/U immediates to XLEN without zero-width replications.
    assign w_imm12     = i_instr[31:20];
    assign w_immu32    = {i_instr[31:12], 12'b0};
    assign w_imm_i     = XLEN'(w_imm12);
    assign w_imm_u     = XLEN'(w_immu32);
    assign w_shamt_imm = XLEN'(i_instr[20 +: SHAMT_W]);
    assign w_shamt_rs2 = XLEN'(i_rs2_data[SHAMT_W-1:0]);

    // Immediate shifts: every imm bit above the shamt field must be zero, bit 30 is SRAI's selector.
    assign w_imm_chk   = i_instr[31:20] & ((w_f3 == F3_SR) ? 12'hBFF : 12'hFFF);
    assign w_shift_bad = |(w_imm_chk >> SHAMT_W);

    // Opcode-driven operand selection; illegal encodings leave operands and selects at zero.
    always_comb begin
        o_op1     = '0;
        o_op2     = '0;
        w_alu_op  = F3_ADD;
        w_alu_ext = F7_BASE;
        w_illegal = 1'b0;
        case (w_opc)
            OPC_OP: begin
                if ((w_f7 == F7_BASE) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)))) begin
                    o_op1     = i_rs1_data;
                    o_op2     = w_is_shift ? w_shamt_rs2 : i_rs2_data;
                    w_alu_op  = w_f3;
                    w_alu_ext = w_f7;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (w_is_shift && w_shift_bad) begin
                    w_illegal = 1'b1;
                end else begin
                    o_op1     = i_rs1_data;
                    o_op2     = w_is_shift ? w_shamt_imm : w_imm_i;
                    w_alu_op  = w_f3;
                    w_alu_ext = ((w_f3 == F3_SR) && i_instr[30]) ? F7_ALT : F7_BASE;
                end
            end
            OPC_LUI: begin
                o_op2 = w_imm_u;
            end
            OPC_AUIPC: begin
                o_op1 = i_pc;
                o_op2 = w_imm_u;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign o_ctrl.illegal = w_illegal;
    assign o_ctrl.rd_we   = !w_illegal && (w_rd != '0);
    assign o_ctrl.rd      = w_rd;
    assign o_ctrl.alu_op  = w_alu_op;
    assign o_ctrl.alu_ext = w_alu_ext;

endmodule

// File: rtl/riscv_alu_issue.sv
// rtl/riscv_alu_issue.sv - ALU issue stage with a 2-entry registered output buffer
module riscv_alu_issue
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       op1,
    output logic [XLEN-1:0]       op2,
    output logic [ALU_OP_W-1:0]   ALU_op,
    output logic [ALU_EXT_W-1:0]  ALU_op_ext,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  rd_we,
    output logic                  illegal
);

    localparam int BW = bundle_w(XLEN);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      r_state;
    logic            r_out_valid;
    logic            r_in_ready;
    logic [BW-1:0]   r_head;
    logic [BW-1:0]   r_skid;

    logic [1:0]      w_state_nxt;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_head_from_dec;
    logic            w_head_from_skid;
    logic            w_skid_load;
    logic [XLEN-1:0] w_dec_op1;
    logic [XLEN-1:0] w_dec_op2;
    alu_ctrl_t       w_dec_ctrl;
    logic [BW-1:0]   w_dec_bundle;
    alu_ctrl_t       w_head_ctrl;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    riscv_alu_operand_dec #(
        .XLEN (XLEN)
    ) u_dec (
        .i_instr    (in_instr),
        .i_pc       (in_pc),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_op1      (w_dec_op1),
        .o_op2      (w_dec_op2),
        .o_ctrl     (w_dec_ctrl)
    );

    assign w_dec_bundle = {w_dec_ctrl, w_dec_op2, w_dec_op1};
    assign w_in_fire    = in_valid && r_in_ready;
    assign w_out_fire   = r_out_valid && out_ready;

    // Buffer FSM: decide the next occupancy and which storage slot each bundle lands in.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_from_dec  = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt     = ST_ONE;
                    w_head_from_dec = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_in_fire, w_out_fire})
                    2'b11: w_head_from_dec = 1'b1;
                    2'b10: begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                    2'b01: w_state_nxt = ST_EMPTY;
                    default: w_state_nxt = ST_ONE;
                endcase
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_head_from_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Occupancy and handshake flags are registered from the next state so in_ready never sees out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    // Head holds the presented bundle; skid catches the second entry while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_head_from_dec) begin
                r_head <= w_dec_bundle;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_skid_load) begin
                r_skid <= w_dec_bundle;
            end
        end
    end

    assign w_head_ctrl = r_head[BW-1 -: CTRL_W];
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign op1         = r_head[XLEN-1:0];
    assign op2         = r_head[2*XLEN-1:XLEN];
    assign ALU_op      = w_head_ctrl.alu_op;
    assign ALU_op_ext  = w_head_ctrl.alu_ext;
    assign rd          = w_head_ctrl.rd;
    assign rd_we       = w_head_ctrl.rd_we;
    assign illegal     = w_head_ctrl.illegal;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb/tb_riscv_alu_issue.sv - self-checking bench for riscv_alu_issue
module tb_riscv_alu_issue;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      ALU_op;
    logic [6:0]      ALU_op_ext;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;

    riscv_alu_issue #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op1        (op1),
        .op2        (op2),
        .ALU_op     (ALU_op),
        .ALU_op_ext (ALU_op_ext),
        .rd         (rd),
        .rd_we      (rd_we),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  aop;
        logic [6:0]  ext;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rf [32];
    exp_t        q [$];
    int          n_pops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each supported instruction, written from the ISA rules.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   f3;
        int   f7;
        int   s;
        bit   ok;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        ok = 1'b1;
        e.op1 = 0; e.op2 = 0; e.aop = 0; e.ext = 0;
        e.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.op1 = a;
                e.op2 = (f3 == 1 || f3 == 5) ? (b % 32) : b;
                e.aop = 3'(f3);
                e.ext = 7'(f7);
            end
            7'h13: begin
                s = int'(ins[31:20]);
                if (s >= 2048) s -= 4096;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 32);
                e.op1 = a;
                e.op2 = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'(s);
                e.aop = 3'(f3);
                e.ext = (f3 == 5 && ins[30]) ? 7'd32 : 7'd0;
            end
            7'h37: e.op2 = ins & 32'hFFFF_F000;
            7'h17: begin
                e.op1 = pc;
                e.op2 = ins & 32'hFFFF_F000;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.op1 = 0; e.op2 = 0; e.aop = 0; e.ext = 0;
        end
        e.ill = !ok;
        e.we  = ok && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 2))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    default: ;
                endcase
            end
            1, 5: begin
                r[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            default: ;
        endcase
        return r;
    endfunction

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        in_instr = ins;
        in_pc    = pc;
        rs1_data = rf[ins[19:15]];
        rs2_data = rf[ins[24:20]];
    endtask

    // One clock: score handshakes seen before the edge, then check occupancy flags after it.
    task automatic cyc();
        bit   in_f;
        bit   out_f;
        exp_t e;
        check("rs1_addr", rs1_addr, in_instr[19:15]);
        check("rs2_addr", rs2_addr, in_instr[24:20]);
        in_f  = in_valid && in_ready;
        out_f = out_valid && out_ready;
        if (out_f) begin
            if (q.size() == 0) begin
                check("unexpected_bundle", 1, 0);
            end else begin
                e = q.pop_front();
                n_pops++;
                check("op1", op1, e.op1);
                check("op2", op2, e.op2);
                check("ALU_op", ALU_op, e.aop);
                check("ALU_op_ext", ALU_op_ext, e.ext);
                check("rd", rd, e.rd);
                check("rd_we", rd_we, e.we);
                check("illegal", illegal, e.ill);
            end
        end
        if (in_f) q.push_back(ref_model(in_instr, in_pc, rs1_data, rs2_data));
        @(posedge clk);
        #1;
        check("out_valid", out_valid, q.size() != 0);
        check("in_ready", in_ready, q.size() < 2);
    endtask

    task automatic issue_one(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        present(ins, pc);
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0000_0013; in_pc = 0; rs1_data = 0; rs2_data = 0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_op1", op1, 0);
        check("rst_rd_we", rd_we, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        cyc();

        // 1: ADD x3,x1,x2
        rf[1] = 5; rf[2] = 7; out_ready = 1'b1;
        issue_one(32'h0020_81B3, 0);
        check("add_valid", out_valid, 1);
        check("add_op1", op1, 5);
        check("add_op2", op2, 7);
        check("add_aop", ALU_op, 0);
        check("add_ext", ALU_op_ext, 0);
        check("add_rd", rd, 3);
        check("add_we", rd_we, 1);
        cyc();

        // 2: SRAI x4,x1,3 and ADDI x6,x1,0x400
        rf[1] = 32'h8000_0000;
        issue_one(32'h4030_D213, 0);
        check("srai_op1", op1, 32'h8000_0000);
        check("srai_op2", op2, 3);
        check("srai_aop", ALU_op, 3'b101);
        check("srai_ext", ALU_op_ext, 7'b0100000);
        check("srai_ill", illegal, 0);
        issue_one(32'h4000_8313, 0);
        check("addi_op2", op2, 32'h400);
        check("addi_ext", ALU_op_ext, 0);
        cyc();

        // 3: backpressure fills the buffer, then drains in order
        out_ready = 1'b0; in_valid = 1'b1;
        present(32'h0020_81B3, 0); cyc();
        present(32'h0011_0233, 0); cyc();
        present(32'h0031_82B3, 0);
        check("full_in_ready", in_ready, 0);
        cyc();
        out_ready = 1'b1;
        cyc();
        check("drain_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("bp_drained", q.size(), 0);

        // 4: eight back-to-back instructions at full throughput
        n_pops = 0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            present({12'(i * 3), 5'(i), 3'b000, 5'(i + 1), 7'h13}, 0);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        check("stream_count", n_pops, 8);

        // 5: AUIPC, LUI x0, unsupported load opcode
        issue_one(32'h1234_5297, 32'h100);
        check("auipc_op1", op1, 32'h100);
        check("auipc_op2", op2, 32'h1234_5000);
        check("auipc_we", rd_we, 1);
        issue_one(32'hABCD_E037, 0);
        check("lui_x0_we", rd_we, 0);
        issue_one(32'h0041_2183, 0);
        check("load_ill", illegal, 1);
        check("load_we", rd_we, 0);
        cyc();

        // Randomised traffic under random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            present(rand_instr(), $urandom);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("rand_drained", q.size(), 0);

        // 6: async reset while FULL
        out_ready = 1'b0; in_valid = 1'b1;
        present(32'h0020_81B3, 0); cyc();
        present(32'h0011_0233, 0); cyc();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("no_stale", n_tests > 0 && out_valid === 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
